// File: rtl/legv8_mc_control.sv
// rtl/legv8_mc_control.sv - multi-cycle LEGv8 sequencer: PC/IR, memory handshakes, phased control
// Optional illegal-opcode trap state enabled by defining LEGV8_MC_TRAP_EN.
module legv8_mc_control #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        CLOCK,
   input  logic        RESET_N,
   output logic        IMEM_REQ,
   input  logic        IMEM_READY,
   input  logic [31:0] IMEM_RDATA,
   output logic        DMEM_REQ,
   input  logic        DMEM_READY,
   input  logic        ALU_ZERO,
   output logic [63:0] PC,
   output logic [31:0] IR,
   output logic        CONTROL_REG2LOC,
   output logic        CONTROL_MEM2REG,
   output logic        CONTROL_ALUSRC,
   output logic        CONTROL_REGWRITE,
   output logic        CONTROL_MEMREAD,
   output logic        CONTROL_MEMWRITE,
   output logic [1:0]  CONTROL_ALU_OP,
   output logic        PC_WRITE,
   output logic [31:0] RETIRED,
   output logic        HALT
);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXEC, MEM, WB
`ifdef LEGV8_MC_TRAP_EN
      , TRAP
`endif
   } state_t;

   state_t      state, state_next;
   logic        run;
   logic        kind_b, kind_cbz, kind_ldr, kind_str;
   logic        ir_load;
   logic [63:0] pc_next;
   logic [10:0] opc;
   logic        dec_b, dec_cbz, dec_ldr, dec_str, dec_r, dec_illegal;
   logic [63:0] br_off, cb_off;

   assign opc         = IR[31:21];
   assign dec_b       = (IR[31:26] == 6'b000101);
   assign dec_cbz     = (IR[31:24] == 8'b10110100);
   assign dec_ldr     = (opc == 11'b11111000010);
   assign dec_str     = (opc == 11'b11111000000);
   assign dec_r       = (opc inside {11'b10001011000, 11'b11001011000,
                                     11'b10001010000, 11'b10101010000});
   assign dec_illegal = !(dec_b || dec_cbz || dec_ldr || dec_str || dec_r);

   assign br_off = {{36{IR[25]}}, IR[25:0], 2'b00};
   assign cb_off = {{43{IR[23]}}, IR[23:5], 2'b00};

`ifdef LEGV8_MC_TRAP_EN
   assign HALT = (state == TRAP);
`else
   assign HALT = 1'b0;
`endif

   // run delays the IDLE->FETCH move so the first fetch lands two edges after reset release
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state            <= IDLE;
         run              <= 1'b0;
         PC               <= RESET_PC;
         IR               <= 32'h0;
         RETIRED          <= 32'h0;
         kind_b           <= 1'b0;
         kind_cbz         <= 1'b0;
         kind_ldr         <= 1'b0;
         kind_str         <= 1'b0;
         CONTROL_REG2LOC  <= 1'b0;
         CONTROL_MEM2REG  <= 1'b0;
         CONTROL_ALUSRC   <= 1'b0;
         CONTROL_MEMREAD  <= 1'b0;
         CONTROL_MEMWRITE <= 1'b0;
         CONTROL_ALU_OP   <= 2'b00;
      end else begin
         state <= state_next;
         run   <= 1'b1;
         if (ir_load) IR <= IMEM_RDATA;
         if (PC_WRITE) begin
            PC      <= pc_next;
            RETIRED <= RETIRED + 32'd1;
         end
         // control bits live from end of DECODE until the retiring cycle
         if (PC_WRITE) begin
            kind_b           <= 1'b0;
            kind_cbz         <= 1'b0;
            kind_ldr         <= 1'b0;
            kind_str         <= 1'b0;
            CONTROL_REG2LOC  <= 1'b0;
            CONTROL_MEM2REG  <= 1'b0;
            CONTROL_ALUSRC   <= 1'b0;
            CONTROL_MEMREAD  <= 1'b0;
            CONTROL_MEMWRITE <= 1'b0;
            CONTROL_ALU_OP   <= 2'b00;
         end else if (state == DECODE) begin
            kind_b           <= dec_b;
            kind_cbz         <= dec_cbz;
            kind_ldr         <= dec_ldr;
            kind_str         <= dec_str;
            CONTROL_REG2LOC  <= dec_str;
            CONTROL_MEM2REG  <= dec_ldr;
            CONTROL_ALUSRC   <= dec_ldr || dec_str;
            CONTROL_MEMREAD  <= dec_ldr;
            CONTROL_MEMWRITE <= dec_str;
            CONTROL_ALU_OP   <= dec_r ? 2'b10 : (dec_cbz ? 2'b01 : 2'b00);
         end
      end
   end

   always_comb begin
      state_next       = state;
      IMEM_REQ         = 1'b0;
      DMEM_REQ         = 1'b0;
      PC_WRITE         = 1'b0;
      CONTROL_REGWRITE = 1'b0;
      ir_load          = 1'b0;
      pc_next          = PC + 64'd4;
      case (state)
         IDLE: begin
            if (run) state_next = FETCH;
         end
         FETCH: begin
            IMEM_REQ = 1'b1;
            if (IMEM_READY) begin
               ir_load    = 1'b1;
               state_next = DECODE;
            end
         end
         DECODE: begin
            if (dec_illegal) begin
`ifdef LEGV8_MC_TRAP_EN
               state_next = TRAP;
`else
               PC_WRITE   = 1'b1;
               state_next = FETCH;
`endif
            end else begin
               state_next = EXEC;
            end
         end
         EXEC: begin
            if (kind_b) begin
               pc_next    = PC + br_off;
               PC_WRITE   = 1'b1;
               state_next = FETCH;
            end else if (kind_cbz) begin
               if (ALU_ZERO) pc_next = PC + cb_off;
               PC_WRITE   = 1'b1;
               state_next = FETCH;
            end else if (kind_ldr || kind_str) begin
               state_next = MEM;
            end else begin
               state_next = WB;
            end
         end
         MEM: begin
            DMEM_REQ = 1'b1;
            if (DMEM_READY) begin
               if (kind_str) begin
                  PC_WRITE   = 1'b1;
                  state_next = FETCH;
               end else begin
                  state_next = WB;
               end
            end
         end
         WB: begin
            CONTROL_REGWRITE = 1'b1;
            PC_WRITE         = 1'b1;
            state_next       = FETCH;
         end
`ifdef LEGV8_MC_TRAP_EN
         TRAP: begin
            state_next = TRAP;
         end
`endif
         default: state_next = IDLE;
      endcase
   end

endmodule
